lw_sha_wr_admit: RTL and testbench

Parametrised write-admission stage between the AXI4 slave adapter's conduit write port and the SHA/HMAC interface control logic. It replaces the immediate accept-or-reject decision on DIN/KEY writes with an ordered, depth-configurable write queue. The queue drains each write to the control logic only when the core can take it, and generates the per-write slave error, overflow and DMA write-request signals. It sits inside the SHA AXI4 top, fed by `con_wr`/`con_waddr`/`con_wdata`.

---
 rtl/lw_sha_pkg.sv | 41 ++++
 rtl/lw_sha_sync_fifo.sv | 70 +++++++
 rtl/lw_sha_wr_admit.sv | 135 +++++++++++++
 tb/tb_lw_sha_wr_admit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lw_sha_pkg.sv
// Shared register map, write classes and queue entry layout for the SHA write path.
// Entry fields are sized for the widest conduit (12-bit address, 32-bit data).
package lw_sha_pkg;

    localparam int LW_ADDR_W = 12;
    localparam int LW_DATA_W = 32;

    localparam logic [LW_ADDR_W-1:0] CFG_ADDR = 12'h000;
    localparam logic [LW_ADDR_W-1:0] CTL_ADDR = 12'h004;
    localparam logic [LW_ADDR_W-1:0] STS_ADDR = 12'h008;
    localparam logic [LW_ADDR_W-1:0] IE_ADDR  = 12'h00C;
    localparam logic [LW_ADDR_W-1:0] DIN_ADDR = 12'h010;
    localparam logic [LW_ADDR_W-1:0] KEY_ADDR = 12'h014;

    typedef enum logic [2:0] {
        DIN = 3'd0,
        KEY = 3'd1,
        CFG = 3'd2,
        STS = 3'd3,
        REG = 3'd4
    } wr_class_e;

    typedef struct packed {
        wr_class_e              cls;
        logic [LW_ADDR_W-1:0]   addr;
        logic [LW_DATA_W-1:0]   data;
    } wr_entry_t;

    // CTL, IE and every unmapped address share the plain-register class.
    function automatic wr_class_e classify(input logic [LW_ADDR_W-1:0] addr);
        case (addr)
            DIN_ADDR:          return DIN;
            KEY_ADDR:          return KEY;
            CFG_ADDR:          return CFG;
            STS_ADDR:          return STS;
            CTL_ADDR, IE_ADDR: return REG;
            default:           return REG;
        endcase
    endfunction

endpackage

// File: rtl/lw_sha_sync_fifo.sv
// Generic synchronous FIFO with registered storage and a combinational head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module lw_sha_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
        empty   = (wr_ptr_q == rd_ptr_q);
        level   = wr_ptr_q - rd_ptr_q;
        head    = mem_q[rd_ptr_q[IDX_W-1:0]];
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = din;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lw_sha_wr_admit.sv
// Write-admission stage: classifies conduit writes, queues the admitted ones in order
// and releases each to the SHA control logic only when the core can take it.
module lw_sha_wr_admit
    import lw_sha_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4,
    parameter int DMA_LWM    = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_wr,
    input  logic [ADDR_WIDTH-1:0]   s_waddr,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    output logic                    s_slv_error,
    output logic                    m_wr,
    output logic [ADDR_WIDTH-1:0]   m_waddr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    core_ready,
    input  logic                    din_ready,
    input  logic                    key_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    dma_wr_req
);

    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = $bits(wr_entry_t);

    logic                   s_slv_error_q, s_slv_error_d;
    logic                   m_wr_q, m_wr_d;
    logic [ADDR_WIDTH-1:0]  m_waddr_q, m_waddr_d;
    logic [DATA_WIDTH-1:0]  m_wdata_q, m_wdata_d;
    logic                   overflow_q, overflow_d;
    logic                   dma_wr_req_q, dma_wr_req_d;
    logic                   holdoff_q, holdoff_d;

    wr_class_e              wr_cls;
    wr_entry_t              push_entry;
    wr_entry_t              head_entry;
    logic [ENTRY_W-1:0]     head_bits;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_level;
    logic                   sts_bad;
    logic                   cfg_bad;
    logic                   push;
    logic                   pop;
    logic                   head_stream;
    logic                   head_ready;

    lw_sha_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .reset (areset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (head_bits)
    );

    // Admission: flush beats everything, then a full queue, then the per-class checks.
    always_comb begin
        wr_cls          = classify(LW_ADDR_W'(s_waddr));
        push_entry.cls  = wr_cls;
        push_entry.addr = LW_ADDR_W'(s_waddr);
        push_entry.data = LW_DATA_W'(s_wdata);

        sts_bad = (wr_cls == STS) && !s_wdata[0] && !s_wdata[3];
        cfg_bad = (wr_cls == CFG) && ((fifo_level != '0) || !core_ready);
        push    = s_wr && !flush && !fifo_full && !sts_bad && !cfg_bad;

        s_slv_error_d = s_slv_error_q;
        if (s_wr) begin
            s_slv_error_d = !flush && (fifo_full || sts_bad || cfg_bad);
        end
        overflow_d   = s_wr && !flush && fifo_full;
        dma_wr_req_d = (fifo_level <= LVL_W'(DMA_LWM)) && !flush;
    end

    // Issue: DIN/KEY heads wait for their ready and skip the holdoff cycle after a stream beat.
    always_comb begin
        head_entry  = wr_entry_t'(head_bits);
        head_stream = (head_entry.cls == DIN) || (head_entry.cls == KEY);
        case (head_entry.cls)
            DIN:     head_ready = din_ready;
            KEY:     head_ready = key_ready;
            default: head_ready = 1'b1;
        endcase

        pop       = !fifo_empty && !flush && head_ready && !(holdoff_q && head_stream);
        holdoff_d = pop && head_stream;

        m_wr_d    = pop;
        m_waddr_d = pop ? ADDR_WIDTH'(head_entry.addr) : m_waddr_q;
        m_wdata_d = pop ? DATA_WIDTH'(head_entry.data) : m_wdata_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            s_slv_error_q <= 1'b0;
            m_wr_q        <= 1'b0;
            m_waddr_q     <= '0;
            m_wdata_q     <= '0;
            overflow_q    <= 1'b0;
            dma_wr_req_q  <= 1'b0;
            holdoff_q     <= 1'b0;
        end else begin
            s_slv_error_q <= s_slv_error_d;
            m_wr_q        <= m_wr_d;
            m_waddr_q     <= m_waddr_d;
            m_wdata_q     <= m_wdata_d;
            overflow_q    <= overflow_d;
            dma_wr_req_q  <= dma_wr_req_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign s_slv_error = s_slv_error_q;
    assign m_wr        = m_wr_q;
    assign m_waddr     = m_waddr_q;
    assign m_wdata     = m_wdata_q;
    assign overflow    = overflow_q;
    assign dma_wr_req  = dma_wr_req_q;
    assign level       = fifo_level;

endmodule

// File: tb/tb_lw_sha_wr_admit.sv
// Directed vector bench for lw_sha_wr_admit (DEPTH=4, DMA_LWM=1); one table row per clock.
module tb_lw_sha_wr_admit;
    import lw_sha_pkg::*;

    logic        aclk;
    logic        areset;
    logic        s_wr;
    logic [11:0] s_waddr;
    logic [31:0] s_wdata;
    logic        s_slv_error;
    logic        m_wr;
    logic [11:0] m_waddr;
    logic [31:0] m_wdata;
    logic        core_ready;
    logic        din_ready;
    logic        key_ready;
    logic        flush;
    logic [2:0]  level;
    logic        overflow;
    logic        dma_wr_req;

    int total = 0;
    int bad   = 0;

    lw_sha_wr_admit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .DEPTH      (4),
        .DMA_LWM    (1)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_wr        (s_wr),
        .s_waddr     (s_waddr),
        .s_wdata     (s_wdata),
        .s_slv_error (s_slv_error),
        .m_wr        (m_wr),
        .m_waddr     (m_waddr),
        .m_wdata     (m_wdata),
        .core_ready  (core_ready),
        .din_ready   (din_ready),
        .key_ready   (key_ready),
        .flush       (flush),
        .level       (level),
        .overflow    (overflow),
        .dma_wr_req  (dma_wr_req)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ctl nibble = {core_ready, din_ready, key_ready, flush}
    typedef struct {
        logic        rst_before;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  ctl;
        logic        e_mwr;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic        e_err;
        logic [2:0]  e_lvl;
        logic        e_ovf;
        logic        e_dma;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rb, input logic wr, input logic [11:0] addr,
                       input logic [31:0] data, input logic [3:0] ctl,
                       input logic e_mwr, input logic [11:0] e_addr, input logic [31:0] e_data,
                       input logic e_err, input logic [2:0] e_lvl, input logic e_ovf,
                       input logic e_dma);
        vec_t v;
        v.rst_before = rb;  v.wr = wr;  v.addr = addr;  v.data = data;  v.ctl = ctl;
        v.e_mwr = e_mwr;  v.e_addr = e_addr;  v.e_data = e_data;  v.e_err = e_err;
        v.e_lvl = e_lvl;  v.e_ovf = e_ovf;  v.e_dma = e_dma;
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input int row, input logic [31:0] got,
                          input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s row=%0d got=0x%0h want=0x%0h", name, row, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_wr       = v.wr;
        s_waddr    = v.addr;
        s_wdata    = v.data;
        core_ready = v.ctl[3];
        din_ready  = v.ctl[2];
        key_ready  = v.ctl[1];
        flush      = v.ctl[0];
    endtask

    task automatic checkOutput(input int row, input vec_t v);
        check1("m_wr", row, {31'd0, m_wr}, {31'd0, v.e_mwr});
        if (v.e_mwr) begin
            check1("m_waddr", row, {20'd0, m_waddr}, {20'd0, v.e_addr});
            check1("m_wdata", row, m_wdata, v.e_data);
        end
        check1("s_slv_error", row, {31'd0, s_slv_error}, {31'd0, v.e_err});
        check1("level", row, {29'd0, level}, {29'd0, v.e_lvl});
        check1("overflow", row, {31'd0, overflow}, {31'd0, v.e_ovf});
        check1("dma_wr_req", row, {31'd0, dma_wr_req}, {31'd0, v.e_dma});
    endtask

    task automatic doReset();
        areset = 1'b1;
        s_wr = 1'b0;  s_waddr = '0;  s_wdata = '0;  flush = 1'b0;
        core_ready = 1'b1;  din_ready = 1'b1;  key_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic step(input int row, input vec_t v);
        applyStimulus(v);
        @(posedge aclk);
        #1;
        checkOutput(row, v);
    endtask

    vec_t hv;

    initial begin
        // A: four back-to-back DIN writes, one issue every other cycle
        add(1,1,DIN_ADDR,32'hA0,4'hE, 0,0,0,            0,1,0,1);
        add(0,1,DIN_ADDR,32'hA1,4'hE, 1,DIN_ADDR,32'hA0, 0,1,0,1);
        add(0,1,DIN_ADDR,32'hA2,4'hE, 0,0,0,            0,2,0,1);
        add(0,1,DIN_ADDR,32'hA3,4'hE, 1,DIN_ADDR,32'hA1, 0,2,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            0,2,0,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hA2, 0,1,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            0,1,0,1);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hA3, 0,0,0,1);
        add(0,0,0,0,4'hE,             0,0,0,            0,0,0,1);
        // B: fill with din_ready low, fifth write overflows, then drain four
        add(1,1,DIN_ADDR,32'hB0,4'hA, 0,0,0,            0,1,0,1);
        add(0,1,DIN_ADDR,32'hB1,4'hA, 0,0,0,            0,2,0,1);
        add(0,1,DIN_ADDR,32'hB2,4'hA, 0,0,0,            0,3,0,0);
        add(0,1,DIN_ADDR,32'hB3,4'hA, 0,0,0,            0,4,0,0);
        add(0,1,DIN_ADDR,32'hB4,4'hA, 0,0,0,            1,4,1,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hB0, 1,3,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            1,3,0,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hB1, 1,2,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            1,2,0,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hB2, 1,1,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            1,1,0,1);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hB3, 1,0,0,1);
        add(0,0,0,0,4'hE,             0,0,0,            1,0,0,1);
        // C: CTL waits behind blocked DIN entries; CFG with non-empty queue is refused
        add(1,1,DIN_ADDR,32'hC0,4'hA, 0,0,0,            0,1,0,1);
        add(0,1,DIN_ADDR,32'hC1,4'hA, 0,0,0,            0,2,0,1);
        add(0,1,CTL_ADDR,32'h1,4'hA,  0,0,0,            0,3,0,0);
        add(0,1,CFG_ADDR,32'h5,4'hA,  0,0,0,            1,3,0,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hC0, 1,2,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            1,2,0,0);
        add(0,0,0,0,4'hE,             1,DIN_ADDR,32'hC1, 1,1,0,0);
        add(0,0,0,0,4'hE,             1,CTL_ADDR,32'h1,  1,0,0,1);
        add(0,0,0,0,4'hE,             0,0,0,            1,0,0,1);
        // D: STS/CFG checks, KEY pacing, IE issuing during holdoff
        add(1,1,STS_ADDR,32'h2,4'hE,  0,0,0,            1,0,0,1);
        add(0,1,STS_ADDR,32'h8,4'hE,  0,0,0,            0,1,0,1);
        add(0,0,0,0,4'hE,             1,STS_ADDR,32'h8,  0,0,0,1);
        add(0,0,0,0,4'hE,             0,0,0,            0,0,0,1);
        add(0,1,CFG_ADDR,32'h3,4'h6,  0,0,0,            1,0,0,1);
        add(0,1,CFG_ADDR,32'h3,4'hE,  0,0,0,            0,1,0,1);
        add(0,0,0,0,4'hE,             1,CFG_ADDR,32'h3,  0,0,0,1);
        add(0,1,KEY_ADDR,32'hC0,4'hE, 0,0,0,            0,1,0,1);
        add(0,1,KEY_ADDR,32'hC1,4'hE, 1,KEY_ADDR,32'hC0, 0,1,0,1);
        add(0,1,IE_ADDR,32'h7,4'hE,   0,0,0,            0,2,0,1);
        add(0,0,0,0,4'hE,             1,KEY_ADDR,32'hC1, 0,1,0,0);
        add(0,0,0,0,4'hE,             1,IE_ADDR,32'h7,   0,0,0,1);
        add(0,0,0,0,4'hE,             0,0,0,            0,0,0,1);
        // E: flush with a concurrent write empties the queue and issues nothing
        add(1,1,DIN_ADDR,32'hE0,4'hA, 0,0,0,            0,1,0,1);
        add(0,1,DIN_ADDR,32'hE1,4'hA, 0,0,0,            0,2,0,1);
        add(0,1,DIN_ADDR,32'hE2,4'hA, 0,0,0,            0,3,0,0);
        add(0,1,DIN_ADDR,32'hE3,4'hF, 0,0,0,            0,0,0,0);
        add(0,0,0,0,4'hE,             0,0,0,            0,0,0,1);

        doReset();
        check1("rst_m_wr", -1, {31'd0, m_wr}, 32'd0);
        check1("rst_level", -1, {29'd0, level}, 32'd0);
        check1("rst_err", -1, {31'd0, s_slv_error}, 32'd0);
        check1("rst_ovf", -1, {31'd0, overflow}, 32'd0);
        check1("rst_dma", -1, {31'd0, dma_wr_req}, 32'd0);
        check1("rst_wdata", -1, m_wdata, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) doReset();
            step(i, vecs[i]);
        end

        // F: reset lands on the cycle a DIN issue would have happened
        doReset();
        hv = '{0,1,STS_ADDR,32'h8,4'hE, 0,0,0, 0,1,0,1};
        step(100, hv);
        hv = '{0,1,DIN_ADDR,32'hF0,4'hA, 1,STS_ADDR,32'h8, 0,1,0,1};
        step(101, hv);
        hv = '{0,1,STS_ADDR,32'h2,4'hA, 0,0,0, 1,1,0,1};
        step(102, hv);
        areset = 1'b1;
        hv = '{0,0,0,0,4'hE, 0,0,0, 0,0,0,0};
        step(103, hv);
        check1("rst_mid_waddr", 103, {20'd0, m_waddr}, 32'd0);
        check1("rst_mid_wdata", 103, m_wdata, 32'd0);
        areset = 1'b0;
        hv = '{0,0,0,0,4'hE, 0,0,0, 0,0,0,1};
        step(104, hv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
